// File: rtl/axis_frame_truncate.sv
// AXI4-Stream frame length limiter: frames longer than max_len are cut at the limit beat,
// marked bad on tuser[0], and their tail is swallowed. Output goes through a 2-entry skid buffer.
module axis_frame_truncate #(
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
  parameter bit ID_ENABLE   = 1'b0,
  parameter int ID_WIDTH    = 8,
  parameter bit DEST_ENABLE = 1'b0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_WIDTH  = 1,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_i,
  input  logic                  s_axis_tvalid_i,
  output logic                  s_axis_tready_o,
  input  logic                  s_axis_tlast_i,
  input  logic [ID_WIDTH-1:0]   s_axis_tid_i,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest_i,
  input  logic [USER_WIDTH-1:0] s_axis_tuser_i,

  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep_o,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic                  m_axis_tlast_o,
  output logic [ID_WIDTH-1:0]   m_axis_tid_o,
  output logic [DEST_WIDTH-1:0] m_axis_tdest_o,
  output logic [USER_WIDTH-1:0] m_axis_tuser_o,

  input  logic [LEN_WIDTH-1:0]  max_len_i,
  output logic                  status_truncated_o,
  output logic [LEN_WIDTH-1:0]  status_frame_len_o
);

  localparam logic [LEN_WIDTH-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [ID_WIDTH-1:0]   id;
    logic [DEST_WIDTH-1:0] dest;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  // ST_PASS: beats forwarded and counted; ST_DROP: tail of a cut frame consumed until tlast
  typedef enum logic {ST_PASS, ST_DROP} state_t;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]   limit_q, limit_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic                   trunc_pulse_q, trunc_pulse_d;

  logic                   accept;
  logic                   first_beat;
  logic [LEN_WIDTH-1:0]   eff_limit;
  logic [LEN_WIDTH-1:0]   cnt_inc;
  logic                   hit_limit;
  logic                   fwd_valid;
  beat_t                  fwd_beat;

  logic                   skid_ready_q, skid_ready_d;
  logic                   m_valid_q, m_valid_d;
  logic                   tmp_valid_q, tmp_valid_d;
  beat_t                  m_beat_q, tmp_beat_q;
  logic                   in_to_out, in_to_tmp, tmp_to_out;

  assign s_axis_tready_o = skid_ready_q | (state_q == ST_DROP);
  assign accept          = s_axis_tvalid_i & s_axis_tready_o;
  assign first_beat      = (cnt_q == '0);
  // The limit is taken live from max_len_i on the first beat and held for the rest of the frame
  assign eff_limit       = first_beat ? max_len_i : limit_q;
  assign cnt_inc         = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + LEN_WIDTH'(1);
  assign hit_limit       = (eff_limit != '0) && (cnt_inc == eff_limit) && !s_axis_tlast_i;
  assign fwd_valid       = accept && (state_q == ST_PASS);

  always_comb begin
    fwd_beat.data    = s_axis_tdata_i;
    fwd_beat.keep    = s_axis_tkeep_i;
    fwd_beat.last    = s_axis_tlast_i | hit_limit;
    fwd_beat.id      = s_axis_tid_i;
    fwd_beat.dest    = s_axis_tdest_i;
    fwd_beat.user    = s_axis_tuser_i;
    fwd_beat.user[0] = s_axis_tuser_i[0] | hit_limit;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    limit_d       = limit_q;
    len_d         = len_q;
    trunc_pulse_d = 1'b0;
    case (state_q)
      ST_PASS: begin
        if (accept) begin
          if (first_beat) begin
            limit_d = max_len_i;
          end
          if (hit_limit) begin
            state_d       = ST_DROP;
            cnt_d         = cnt_inc;
            len_d         = cnt_inc;
            trunc_pulse_d = 1'b1;
          end else if (s_axis_tlast_i) begin
            cnt_d = '0;
            len_d = cnt_inc;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_DROP: begin
        if (accept && s_axis_tlast_i) begin
          state_d = ST_PASS;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_PASS;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_PASS;
      cnt_q         <= '0;
      limit_q       <= '0;
      len_q         <= '0;
      trunc_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      limit_q       <= limit_d;
      len_q         <= len_d;
      trunc_pulse_q <= trunc_pulse_d;
    end
  end

  // Skid control: the ready register only ever rises when the temp slot is guaranteed free
  always_comb begin
    m_valid_d    = m_valid_q;
    tmp_valid_d  = tmp_valid_q;
    in_to_out    = 1'b0;
    in_to_tmp    = 1'b0;
    tmp_to_out   = 1'b0;
    skid_ready_d = m_axis_tready_i | (!tmp_valid_q & (!m_valid_q | !fwd_valid));
    if (skid_ready_q) begin
      if (m_axis_tready_i || !m_valid_q) begin
        m_valid_d = fwd_valid;
        in_to_out = 1'b1;
      end else begin
        tmp_valid_d = fwd_valid;
        in_to_tmp   = 1'b1;
      end
    end else if (m_axis_tready_i) begin
      m_valid_d   = tmp_valid_q;
      tmp_valid_d = 1'b0;
      tmp_to_out  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_ready_q <= 1'b0;
      m_valid_q    <= 1'b0;
      tmp_valid_q  <= 1'b0;
    end else begin
      skid_ready_q <= skid_ready_d;
      m_valid_q    <= m_valid_d;
      tmp_valid_q  <= tmp_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_to_out) begin
      m_beat_q <= fwd_beat;
    end else if (tmp_to_out) begin
      m_beat_q <= tmp_beat_q;
    end
    if (in_to_tmp) begin
      tmp_beat_q <= fwd_beat;
    end
  end

  assign m_axis_tvalid_o    = m_valid_q;
  assign m_axis_tdata_o     = m_beat_q.data;
  assign m_axis_tkeep_o     = KEEP_ENABLE ? m_beat_q.keep : '1;
  assign m_axis_tlast_o     = m_beat_q.last;
  assign m_axis_tid_o       = ID_ENABLE ? m_beat_q.id : '0;
  assign m_axis_tdest_o     = DEST_ENABLE ? m_beat_q.dest : '0;
  assign m_axis_tuser_o     = m_beat_q.user;
  assign status_truncated_o = trunc_pulse_q;
  assign status_frame_len_o = len_q;

endmodule

// File: tb/tb_axis_frame_truncate.sv
// Directed bench for axis_frame_truncate: driver queues expected beats, a negedge monitor pops
// and compares each output handshake. LEN_WIDTH is narrowed so counter saturation is reachable.
module tb_axis_frame_truncate;
  localparam int DW = 8;
  localparam int KW = 1;
  localparam int IW = 8;
  localparam int DSW = 8;
  localparam int UW = 1;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [IW-1:0] s_tid;
  logic [DSW-1:0] s_tdest;
  logic [UW-1:0] s_tuser;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [IW-1:0] m_tid;
  logic [DSW-1:0] m_tdest;
  logic [UW-1:0] m_tuser;
  logic [LW-1:0] max_len;
  logic          status_truncated;
  logic [LW-1:0] status_frame_len;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    pulses = 0;
  bit    mon_en = 1'b0;
  int    ready_mode = 0;

  always #5 clk = ~clk;

  axis_frame_truncate #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW), .DEST_WIDTH(DSW),
    .USER_WIDTH(UW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata_i(s_tdata), .s_axis_tkeep_i(s_tkeep), .s_axis_tvalid_i(s_tvalid),
    .s_axis_tready_o(s_tready), .s_axis_tlast_i(s_tlast), .s_axis_tid_i(s_tid),
    .s_axis_tdest_i(s_tdest), .s_axis_tuser_i(s_tuser),
    .m_axis_tdata_o(m_tdata), .m_axis_tkeep_o(m_tkeep), .m_axis_tvalid_o(m_tvalid),
    .m_axis_tready_i(m_tready), .m_axis_tlast_o(m_tlast), .m_axis_tid_o(m_tid),
    .m_axis_tdest_o(m_tdest), .m_axis_tuser_o(m_tuser),
    .max_len_i(max_len), .status_truncated_o(status_truncated),
    .status_frame_len_o(status_frame_len)
  );

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    beat_t e;
    if (mon_en && status_truncated) pulses++;
    if (mon_en && m_tvalid && m_tready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL out_beat: got unexpected data=%h last=%b user=%b, required no beat",
                 m_tdata, m_tlast, m_tuser[0]);
      end else begin
        e = exp_q.pop_front();
        if (m_tdata !== e.data || m_tlast !== e.last || m_tuser[0] !== e.user ||
            m_tkeep !== 1'b1 || m_tid !== '0 || m_tdest !== '0) begin
          bad++;
          $display("FAIL out_beat: got data=%h last=%b user=%b keep=%b id=%h dest=%h, required data=%h last=%b user=%b keep=1 id=0 dest=0",
                   m_tdata, m_tlast, m_tuser[0], m_tkeep, m_tid, m_tdest, e.data, e.last, e.user);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the posedge on which the beat transferred.
  task automatic drive_beat(input int d, input bit l, output int stalls);
    bit ok;
    s_tdata  = 8'(d);
    s_tlast  = l;
    s_tuser  = '0;
    s_tvalid = 1'b1;
    stalls   = 0;
    ok       = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
      stalls++;
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n, input int base, input int lim, input int chg,
                            output int stalls);
    bit trunc;
    int exp_len;
    int p0;
    int st;
    trunc   = 1'b0;
    exp_len = (n > 15) ? 15 : n;
    for (int i = 0; i < n; i++) begin
      if (lim != 0 && i + 1 == lim && i != n - 1) begin
        exp_q.push_back({8'(base + i), 1'b1, 1'b1});
        trunc   = 1'b1;
        exp_len = lim;
        break;
      end
      exp_q.push_back({8'(base + i), (i == n - 1), 1'b0});
    end
    max_len = LW'(lim);
    p0      = pulses;
    stalls  = 0;
    for (int i = 0; i < n; i++) begin
      drive_beat(base + i, (i == n - 1), st);
      stalls += st;
      if (i == 0 && chg >= 0) max_len = LW'(chg);
    end
    s_tvalid = 1'b0;
    check("frame_len", status_frame_len, exp_len);
    check("trunc_pulses", pulses - p0, trunc);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    int tot_st;
    rst = 1'b1;
    s_tdata = '0; s_tkeep = '1; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tid = '0; s_tdest = '0; s_tuser = '0; max_len = '0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_status_trunc", status_truncated, 0);
    check("rst_status_len", status_frame_len, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("tready_not_yet", s_tready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("tready_rises", s_tready, 1);
    @(posedge clk); #1;

    send_frame(3, 'hA0, 4, -1, st);
    send_frame(4, 'hB0, 4, -1, st);
    wait_drain();

    send_frame(7, 'h10, 4, -1, st);
    check("drop_stalls", st, 0);
    send_frame(3, 'h20, 4, -1, st);
    wait_drain();

    tot_st = 0;
    send_frame(3, 'h40, 0, -1, st); tot_st += st;
    send_frame(5, 'h48, 0, -1, st); tot_st += st;
    send_frame(2, 'h50, 0, -1, st); tot_st += st;
    check("full_rate_stalls", tot_st, 0);
    wait_drain();

    ready_mode = 1;
    send_frame(4, 'h60, 0, -1, st);
    send_frame(6, 'h68, 0, -1, st);
    send_frame(1, 'h70, 0, -1, st);
    send_frame(3, 'h78, 0, -1, st);
    wait_drain();
    ready_mode = 0;
    @(posedge clk); #1;

    send_frame(5, 'h30, 2, 8, st);
    send_frame(5, 'h38, 8, -1, st);
    wait_drain();

    send_frame(20, 'h80, 0, -1, st);
    wait_drain();

    send_frame(3, 'hA8, 1, -1, st);
    send_frame(1, 'hAC, 1, -1, st);
    wait_drain();

    exp_q.push_back({8'hC0, 1'b0, 1'b0});
    exp_q.push_back({8'hC1, 1'b0, 1'b0});
    max_len = '0;
    drive_beat('hC0, 1'b0, st);
    drive_beat('hC1, 1'b0, st);
    s_tdata  = 8'hC2;
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    rst      = 1'b1;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    check("rst_mid_m_tvalid", m_tvalid, 0);
    check("rst_mid_s_tready", s_tready, 0);
    check("rst_mid_len", status_frame_len, 0);
    @(posedge clk); #1;
    send_frame(2, 'hD0, 0, -1, st);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
